// File: rtl/l_step_dispatch_octa_if.sv
// Lane start/finished handshake bundle for the eight-lane step dispatcher.
//   go            PS start request
//   clear         synchronous soft clear
//   lane_finished per-lane completion, bit i = lane i
//   lane_start    one-cycle broadcast start pulse
//   l_step        completed-step count
//   busy          a run is in progress
//   all_done      run complete, held until clear
//   timeout_err   sticky watchdog error
// Modport slave is the dispatcher; modport master is the PS/lane side.
interface l_step_dispatch_octa_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  go;
    logic                  clear;
    logic [7:0]            lane_finished;
    logic [7:0]            lane_start;
    logic [DATA_WIDTH-1:0] l_step;
    logic                  busy;
    logic                  all_done;
    logic                  timeout_err;

    modport master (
        output go, clear, lane_finished,
        input  lane_start, l_step, busy, all_done, timeout_err
    );

    modport slave (
        input  go, clear, lane_finished,
        output lane_start, l_step, busy, all_done, timeout_err
    );
endinterface

// File: rtl/l_step_dispatch_octa.sv
// Step dispatcher for the eight-lane diffusion array.
// On go it broadcasts a start pulse to all lanes, gathers each lane's finished bit into a
// sticky mask and advances l_step once all eight have reported, repeating MAX_STEPS times,
// then holds all_done until clear.
// Ports:
//   clk    single clock, posedge
//   rst_n  asynchronous active-low reset
//   bus    l_step_dispatch_octa_if.slave (go, clear, lane_finished in;
//          lane_start, l_step, busy, all_done, timeout_err out)
// Optional feature: define L_STEP_TIMEOUT_EN to enable the per-step watchdog
// (TIMEOUT_CYCLES WAIT cycles); without it timeout_err is constant 0.
module l_step_dispatch_octa #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MAX_STEPS      = 7,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input logic                  clk,
    input logic                  rst_n,
    l_step_dispatch_octa_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StArm,
        StWait,
        StAdvance,
        StDone
    } state_e;

    localparam logic [DATA_WIDTH-1:0] LastStep = DATA_WIDTH'(MAX_STEPS);

    state_e                state_q, state_d;
    logic [7:0]            done_mask_q;
    logic [7:0]            mask_next;
    logic                  mask_full;
    logic [DATA_WIDTH-1:0] l_step_q;
    logic [DATA_WIDTH-1:0] l_step_inc;
    logic [7:0]            lane_start_q;
    logic                  busy_q;
    logic                  all_done_q;
    logic                  timeout_hit;

    assign mask_next  = done_mask_q | bus.lane_finished;
    assign mask_full  = (mask_next == 8'hFF);
    assign l_step_inc = l_step_q + DATA_WIDTH'(1);

`ifdef L_STEP_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] wait_cnt_q;
    logic            timeout_err_q;

    // Completion in the same cycle as the limit is treated as a normal finish.
    assign timeout_hit = (state_q == StWait) && !mask_full
                         && ((wait_cnt_q + CntW'(1)) == CntW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else if (bus.clear) begin
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (state_q == StLaunch) begin
                wait_cnt_q <= '0;
            end else if (state_q == StWait) begin
                wait_cnt_q <= wait_cnt_q + CntW'(1);
            end
            if (timeout_hit) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    assign timeout_hit     = 1'b0;
    // The watchdog limit has no effect in this build.
    assign bus.timeout_err = (TIMEOUT_CYCLES == 0) ? 1'b0 : 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.go) begin
                        state_d = (MAX_STEPS == 0) ? StDone : StLaunch;
                    end
                end
                StLaunch:  state_d = StArm;
                // Guard cycle: finished bits left over from the previous step are dropped.
                StArm:     state_d = StWait;
                StWait: begin
                    if (mask_full) begin
                        state_d = StAdvance;
                    end else if (timeout_hit) begin
                        state_d = StDone;
                    end
                end
                StAdvance: state_d = (l_step_inc == LastStep) ? StDone : StLaunch;
                StDone:    state_d = StDone;
                default:   state_d = StIdle;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            done_mask_q  <= 8'h00;
            l_step_q     <= '0;
            lane_start_q <= 8'h00;
            busy_q       <= 1'b0;
            all_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_start_q <= (state_d == StLaunch) ? 8'hFF : 8'h00;
            busy_q       <= state_d inside {StLaunch, StArm, StWait, StAdvance};
            all_done_q   <= (state_d == StDone);
            if (bus.clear) begin
                done_mask_q <= 8'h00;
                l_step_q    <= '0;
            end else begin
                if (state_q == StLaunch) begin
                    done_mask_q <= 8'h00;
                end else if (state_q == StWait) begin
                    done_mask_q <= mask_next;
                end
                if (state_q == StAdvance) begin
                    l_step_q <= l_step_inc;
                end
            end
        end
    end

    assign bus.lane_start = lane_start_q;
    assign bus.l_step     = l_step_q;
    assign bus.busy       = busy_q;
    assign bus.all_done   = all_done_q;

endmodule

// File: tb/tb_l_step_dispatch_octa.sv
module tb_l_step_dispatch_octa;

    localparam int unsigned Dw       = 32;
    localparam int unsigned MaxSteps = 7;
    localparam int unsigned Tmo      = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   cyc;
    int   exp_lat;

    always #5 clk = ~clk;

    l_step_dispatch_octa_if #(.DATA_WIDTH(Dw)) bus ();
    l_step_dispatch_octa_if #(.DATA_WIDTH(Dw)) bus0 ();

    l_step_dispatch_octa #(
        .DATA_WIDTH    (Dw),
        .MAX_STEPS     (MaxSteps),
        .TIMEOUT_CYCLES(Tmo)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    l_step_dispatch_octa #(
        .DATA_WIDTH    (Dw),
        .MAX_STEPS     (0),
        .TIMEOUT_CYCLES(Tmo)
    ) dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus0.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_start"}, bus.lane_start, 8'h00);
        check({tag, "_step"}, bus.l_step, 0);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_done"}, bus.all_done, 1'b0);
        check({tag, "_tmo"}, bus.timeout_err, 1'b0);
    endtask

    // One step at the transaction level: the step ends m+3 cycles after its LAUNCH, where m
    // is the WAIT cycle in which the last lane's finished bit is first seen.
    // mode 0: all lanes at WAIT 1; 1: lane i pulses at WAIT 2i+1;
    // mode 2: stale level through LAUNCH/ARM, reasserted at WAIT 6; 3: random.
    task automatic run_step(input int k, input int mode);
        int         off[8];
        bit         level;
        logic [7:0] stale;
        logic [7:0] lf;
        int         m;
        level = 1'b0;
        stale = 8'h00;
        for (int i = 0; i < 8; i++) begin
            case (mode)
                0:       off[i] = 1;
                1:       off[i] = 2 * i + 1;
                2:       off[i] = 6;
                default: off[i] = int'($urandom_range(1, 12));
            endcase
        end
        if (mode == 2) begin
            level = 1'b1;
            stale = 8'hFF;
        end else if (mode == 3) begin
            level = 1'($urandom_range(0, 1));
            stale = 8'($urandom);
        end
        m = 0;
        for (int i = 0; i < 8; i++) begin
            if (off[i] > m) m = off[i];
        end
        exp_lat += m + 3;

        check("launch_pulse", bus.lane_start, 8'hFF);
        check("launch_step", bus.l_step, 64'(k));
        check("launch_busy", bus.busy, 1'b1);
        bus.lane_finished = stale;
        tick();
        check("arm_pulse", bus.lane_start, 8'h00);
        bus.lane_finished = stale;
        for (int w = 1; w <= m; w++) begin
            tick();
            check("wait_pulse", bus.lane_start, 8'h00);
            check("wait_step", bus.l_step, 64'(k));
            check("wait_done", bus.all_done, 1'b0);
            lf = 8'h00;
            for (int i = 0; i < 8; i++) begin
                lf[i] = level ? (off[i] <= w) : (off[i] == w);
            end
            bus.lane_finished = lf;
        end
        tick();
        check("adv_pulse", bus.lane_start, 8'h00);
        check("adv_step", bus.l_step, 64'(k));
        check("adv_busy", bus.busy, 1'b1);
        bus.lane_finished = 8'($urandom);
        tick();
        check("next_step", bus.l_step, 64'(k + 1));
        bus.lane_finished = 8'h00;
        if (k + 1 == int'(MaxSteps)) begin
            check("final_done", bus.all_done, 1'b1);
            check("final_busy", bus.busy, 1'b0);
            check("final_pulse", bus.lane_start, 8'h00);
        end
    endtask

    task automatic run_full(input int mode);
        int start;
        exp_lat = 0;
        start = cyc;
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        for (int k = 0; k < int'(MaxSteps); k++) begin
            run_step(k, mode);
        end
        check("run_latency", 64'(cyc - start), 64'(exp_lat + 1));
        // DONE ignores go and lane activity.
        bus.go = 1'b1;
        repeat (3) begin
            bus.lane_finished = 8'($urandom);
            tick();
            check("hold_done", bus.all_done, 1'b1);
            check("hold_step", bus.l_step, 64'(MaxSteps));
            check("hold_pulse", bus.lane_start, 8'h00);
        end
        bus.go = 1'b0;
        bus.lane_finished = 8'h00;
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check_idle("after_clear");
    endtask

    task automatic run_clear_mid();
        exp_lat = 0;
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        for (int k = 0; k < 3; k++) begin
            run_step(k, 0);
        end
        check("s3_pulse", bus.lane_start, 8'hFF);
        check("s3_step", bus.l_step, 3);
        tick();
        tick();
        tick();
        // Second WAIT cycle: clear, go and a completing mask all at once.
        bus.clear = 1'b1;
        bus.go = 1'b1;
        bus.lane_finished = 8'hFF;
        tick();
        bus.clear = 1'b0;
        bus.go = 1'b0;
        bus.lane_finished = 8'h00;
        check_idle("clear_wait");
        repeat (4) begin
            tick();
            check("idle_pulse", bus.lane_start, 8'h00);
            check("idle_busy", bus.busy, 1'b0);
        end
        run_full(0);
    endtask

    task automatic run_timeout();
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        check("tmo_launch", bus.lane_start, 8'hFF);
        bus.lane_finished = 8'hDF;
        tick();
        for (int w = 1; w <= int'(Tmo); w++) begin
            tick();
            check("tmo_wait_busy", bus.busy, 1'b1);
            check("tmo_wait_err", bus.timeout_err, 1'b0);
            check("tmo_wait_pulse", bus.lane_start, 8'h00);
            bus.lane_finished = 8'hDF;
        end
`ifdef L_STEP_TIMEOUT_EN
        repeat (3) begin
            tick();
            check("tmo_done", bus.all_done, 1'b1);
            check("tmo_err", bus.timeout_err, 1'b1);
            check("tmo_step", bus.l_step, 0);
            check("tmo_busy", bus.busy, 1'b0);
        end
`else
        repeat (24) begin
            tick();
            check("stall_busy", bus.busy, 1'b1);
            check("stall_err", bus.timeout_err, 1'b0);
            check("stall_pulse", bus.lane_start, 8'h00);
            check("stall_step", bus.l_step, 0);
        end
`endif
        bus.lane_finished = 8'h00;
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check_idle("tmo_clear");
    endtask

    task automatic run_max0();
        bus0.go = 1'b1;
        tick();
        bus0.go = 1'b0;
        repeat (3) begin
            check("m0_done", bus0.all_done, 1'b1);
            check("m0_pulse", bus0.lane_start, 8'h00);
            check("m0_step", bus0.l_step, 0);
            check("m0_busy", bus0.busy, 1'b0);
            bus0.lane_finished = 8'($urandom);
            tick();
        end
        bus0.lane_finished = 8'h00;
        bus0.clear = 1'b1;
        tick();
        bus0.clear = 1'b0;
        check("m0_clear_done", bus0.all_done, 1'b0);
    endtask

    task automatic run_async_reset();
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        tick();
        rst_n = 1'b1;
        tick();
        check_idle("post_async_rst");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_pass = 0;
        cyc = 0;
        exp_lat = 0;
        bus.go = 1'b0;
        bus.clear = 1'b0;
        bus.lane_finished = 8'h00;
        bus0.go = 1'b0;
        bus0.clear = 1'b0;
        bus0.lane_finished = 8'h00;
        rst_n = 1'b0;
        repeat (3) tick();
        check_idle("reset");
        check("reset_m0_done", bus0.all_done, 1'b0);
        #2;
        rst_n = 1'b1;
        tick();
        check_idle("post_reset");

        run_full(0);
        run_full(1);
        run_full(2);
        repeat (3) run_full(3);
        run_clear_mid();
        run_timeout();
        run_max0();
        run_async_reset();
        run_full(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/l_step_dispatch_octa.md
# l_step_dispatch_octa

Step dispatcher for the eight-lane diffusion array. It is the initiating side of the lane start/finished handshake. On a PS `go` it broadcasts a one-cycle start pulse to all eight diffusion lanes, collects each lane's `finished` into a sticky mask, and advances `l_step` once every lane has reported. It repeats this until `MAX_STEPS` steps are complete, then holds `all_done` until the PS clears it.

## Interface
- `DATA_WIDTH`, 32, width of `l_step`
- `MAX_STEPS`, 7, number of diffusion steps per run; 0 is legal
- `TIMEOUT_CYCLES`, 65535, per-step watchdog limit; used only with `L_STEP_TIMEOUT_EN`

- `clk`  in  1  single clock; all logic on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `go`  in  1  PS start request; sampled only in IDLE
- `clear`  in  1  synchronous soft clear; any state to IDLE
- `lane_finished`  in  8  per-lane completion; bit i = lane i; pulse or level
- `lane_start`  out  8  one-cycle start pulse to all lanes (8'hFF or 8'h00)
- `l_step`  out  DATA_WIDTH  completed-step count
- `busy`  out  1  high in LAUNCH/ARM/WAIT/ADVANCE
- `all_done`  out  1  high in DONE
- `timeout_err`  out  1  sticky watchdog error; tied 0 without the macro

## Operation
- All outputs are registered or decoded from state.
- Under `rst_n` low: state IDLE, `l_step`=0, `lane_start`=0, `busy`=0, `all_done`=0, `timeout_err`=0, `done_mask`=0.
- IDLE: if `go`, go to LAUNCH. With `MAX_STEPS`==0, go to DONE instead.
- LAUNCH: `lane_start`=8'hFF for exactly one cycle; `done_mask` cleared. Next state ARM.
- ARM: guard cycle. `lane_finished` is ignored here, so stale level-finished from the previous step is discarded. Next state WAIT.
- WAIT: each cycle `done_mask` <= `done_mask` | `lane_finished`.
  - When (`done_mask` | `lane_finished`) == 8'hFF, go to ADVANCE.
  - Lanes may finish in any order, in any cycle, or all at once.
- ADVANCE: `l_step` <= `l_step`+1.
  - If the new value == `MAX_STEPS`, go to DONE; otherwise go to LAUNCH.
  - `l_step` never exceeds `MAX_STEPS`.
- DONE: `all_done`=1 and `l_step` held. `go` is ignored; only `clear` leaves DONE.
- `clear` (any state) wins over `go` and over any WAIT completion. Next state IDLE, `l_step`=0, `done_mask`=0, `timeout_err`=0. No start pulse is issued.
- `rst_n` asserted mid-run returns every output to its reset value immediately (asynchronously).
- `lane_finished` bits outside WAIT never affect `l_step`.
- `l_step` arithmetic is unsigned DATA_WIDTH; no wrap is possible because of the `MAX_STEPS` bound.

## Timing
- `go` sampled high at edge 0: `lane_start`=8'hFF in cycle 1, ARM in cycle 2, WAIT from cycle 3.
- Minimum step period is 4 cycles (LAUNCH, ARM, 1×WAIT, ADVANCE), reached when all finished bits are high in the first WAIT cycle.
- The `l_step` increment is visible the cycle after ADVANCE, which is the same cycle as the next LAUNCH or DONE.
- Minimum run latency from `go` to `all_done` = 4·`MAX_STEPS`+1 cycles.
- `clear` takes effect at the next edge; outputs are at IDLE values one cycle later.

## Configuration
- Macro: `L_STEP_TIMEOUT_EN`.
- Defined:
  - A cycle counter is cleared in LAUNCH and increments in WAIT.
  - If it reaches `TIMEOUT_CYCLES` before the mask completes, `timeout_err` is set (sticky) and the state goes to DONE with `l_step` unchanged.
  - `all_done` and `timeout_err` are then both high.
- Undefined: no counter; WAIT may last indefinitely; `timeout_err` is constant 0.

## Test plan
- Reset, then `go`, with all lanes finishing immediately, `MAX_STEPS`=7:
  - exactly 7 `lane_start` pulses, 4 cycles apart;
  - `l_step` goes 0 to 7;
  - `all_done` asserted at cycle 29 and held.
- Staggered finish: lanes 0–7 pulse finished individually at WAIT cycles 1, 3, …, 15 → ADVANCE only after lane 7's pulse; `l_step` increments by 1 per step.
- Stale level: all `lane_finished` held high through LAUNCH/ARM, then dropped in the first WAIT cycle and reasserted 5 cycles later → no early ADVANCE; the step completes after reassertion.
- `clear` in WAIT of step 3, with `go` asserted in the same cycle → IDLE, `l_step`=0, no `lane_start`. A later `go` restarts from step 0.
- `MAX_STEPS`=0: `go` → DONE next cycle, `lane_start` never pulses, `l_step`=0.
- With `L_STEP_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, lane 5 never finishes:
  - `timeout_err`=1 and `all_done`=1 after 16 WAIT cycles, with `l_step` unchanged;
  - `clear` → both return to 0.
